// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting-machine audit path.
// The readout blocks reuse vote_entry_t, so keep field order stable.
package vote_pkg;

    localparam int NUM_CAND = 4;
    localparam int CAND_W   = 2;
    localparam int VOTE_W   = 8;
    localparam int TS_W     = 16;
    localparam int ERR_W    = 8;

    typedef struct packed {
        logic [CAND_W-1:0] cand;
        logic [VOTE_W-1:0] seq;
        logic [TS_W-1:0]   ts;
    } vote_entry_t;

    // Candidate 1 (bit 0) wins when several buttons fire together.
    function automatic logic [CAND_W-1:0] lowest_cand(input logic [NUM_CAND-1:0] v);
        logic [CAND_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CAND_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [NUM_CAND-1:0] v);
        return (v & (v - NUM_CAND'(1))) != '0;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/vote_fifo.sv
// Generic synchronous FIFO with a registered head word; push into an empty
// FIFO becomes visible the following cycle, pops sustain one entry per cycle.
module vote_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [7:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW:0]     level_reg, level_next;
    logic [AW:0]     level_after_pop;
    entry_t          head_reg, head_next;
    logic            do_push, do_pop;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == (AW+1)'(DEPTH));
    assign level = level_reg;
    assign head  = head_reg;

    // A pop frees a slot, so a full FIFO can still take a push in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign level_after_pop = level_reg - (AW+1)'(do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            level_next = level_after_pop + (AW+1)'(do_push);
        end
    end

    // Prefetch the next head; forward the incoming word when it lands in an empty slot.
    always_comb begin
        head_next = head_reg;
        if (!clear && level_next != '0) begin
            if (do_push && level_after_pop == '0) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/vote_audit_log.sv
// Audit stage: tags each accepted vote with candidate, sequence and timestamp
// and queues it for a valid/ready consumer, counting drops and multi-presses.
module vote_audit_log
    import vote_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [NUM_CAND-1:0]    vote_valid,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CAND_W-1:0]      out_cand,
    output logic [VOTE_W-1:0]      out_seq,
    output logic [TS_WIDTH-1:0]    out_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic [ERR_W-1:0]       dropped,
    output logic [ERR_W-1:0]       collisions
);

    typedef struct packed {
        logic [CAND_W-1:0]   cand;
        logic [VOTE_W-1:0]   seq;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    logic [TS_WIDTH-1:0] ts_reg;
    logic [VOTE_W-1:0]   seq_reg, seq_next;
    logic [ERR_W-1:0]    dropped_reg, dropped_next;
    logic [ERR_W-1:0]    collisions_reg, collisions_next;
    logic                push_req, pop, accepted;
    logic                fifo_empty, fifo_full;
    entry_t              push_entry, head_entry;

    assign push_req = !mode && (vote_valid != '0);
    assign pop      = out_valid && out_ready;
    // Same acceptance rule the FIFO applies, so seq only advances on stored entries.
    assign accepted = push_req && !clear && (!fifo_full || pop);

    assign push_entry.cand = lowest_cand(vote_valid);
    assign push_entry.seq  = seq_reg;
    assign push_entry.ts   = ts_reg;

    vote_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (out_ready),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign out_valid  = !fifo_empty;
    assign full       = fifo_full;
    assign out_cand   = head_entry.cand;
    assign out_seq    = head_entry.seq;
    assign out_ts     = head_entry.ts;
    assign dropped    = dropped_reg;
    assign collisions = collisions_reg;

    always_comb begin
        seq_next        = seq_reg;
        dropped_next    = dropped_reg;
        collisions_next = collisions_reg;
        if (clear) begin
            dropped_next    = '0;
            collisions_next = '0;
        end else begin
            if (accepted) begin
                seq_next = seq_reg + VOTE_W'(1);
            end
            if (push_req && fifo_full && !pop) begin
                dropped_next = sat_inc(dropped_reg);
            end
            if (push_req && multi_hot(vote_valid)) begin
                collisions_next = sat_inc(collisions_reg);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_reg         <= '0;
            seq_reg        <= '0;
            dropped_reg    <= '0;
            collisions_reg <= '0;
        end else begin
            ts_reg         <= ts_reg + TS_WIDTH'(1);
            seq_reg        <= seq_next;
            dropped_reg    <= dropped_next;
            collisions_reg <= collisions_next;
        end
    end

endmodule

// File: tb/tb_vote_audit_log.sv
// Self-checking bench for vote_audit_log: directed vector table, hand-written
// fill/drain and wrap sequences, then randomized traffic against a queue model.
module tb_vote_audit_log;
    import vote_pkg::*;

    localparam int DEPTH    = 16;
    localparam int TS_WIDTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  vote_valid = 4'b0;
    logic        out_valid, full;
    logic [1:0]  out_cand;
    logic [7:0]  out_seq, dropped, collisions;
    logic [15:0] out_ts;
    logic [4:0]  level;

    always #5 clock = ~clock;

    vote_audit_log #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .vote_valid (vote_valid),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cand   (out_cand),
        .out_seq    (out_seq),
        .out_ts     (out_ts),
        .level      (level),
        .full       (full),
        .dropped    (dropped),
        .collisions (collisions)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cand;
        int seq;
        int ts;
    } mentry_t;

    mentry_t q[$];
    int m_seq, m_ts, m_drop, m_coll;

    typedef struct {
        logic       m;
        logic [3:0] vv;
        logic       clr;
        logic       rdy;
        int         ev;
        int         ec;
        int         es;
        int         ets;
        int         elev;
        int         ecoll;
        int         edrop;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour at one clock edge, from the rules of the audit log.
    task automatic model_edge();
        bit      popped;
        int      cand;
        mentry_t e;
        if (reset) begin
            q.delete();
            m_seq = 0; m_ts = 0; m_drop = 0; m_coll = 0;
            return;
        end
        if (clear) begin
            q.delete();
            m_drop = 0;
            m_coll = 0;
        end else begin
            popped = (q.size() > 0) && out_ready;
            if (popped) void'(q.pop_front());
            if (!mode && vote_valid != 0) begin
                if ($countones(vote_valid) > 1 && m_coll < 255) m_coll++;
                cand = -1;
                for (int i = 0; i < 4; i++) if (cand < 0 && vote_valid[i]) cand = i;
                if (q.size() < DEPTH) begin
                    e.cand = cand; e.seq = m_seq; e.ts = m_ts;
                    q.push_back(e);
                    m_seq = (m_seq + 1) % 256;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic step(input logic m, input logic [3:0] vv, input logic clr, input logic rdy);
        mode = m; vote_valid = vv; clear = clr; out_ready = rdy;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, out_valid, q.size() > 0);
        check({tag, ".level"}, level, q.size());
        check({tag, ".full"}, full, q.size() == DEPTH);
        check({tag, ".dropped"}, dropped, m_drop);
        check({tag, ".collisions"}, collisions, m_coll);
        if (q.size() > 0) begin
            check({tag, ".out_cand"}, out_cand, q[0].cand);
            check({tag, ".out_seq"}, out_seq, q[0].seq);
            check({tag, ".out_ts"}, out_ts, q[0].ts);
        end
    endtask

    function automatic logic [3:0] rand_vote();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 4'b0000;
        if (r < 8) return 4'b0001 << $urandom_range(0, 3);
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0;
        int  last_seq;
        bit  saw_wrap;
        logic [3:0] vv;

        // Row i is applied in cycle i after reset, i.e. with timestamp i.
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[5]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1, 2, 0, 5,  1, 0, 0};
        vecs[6]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 1, 2, 0, 5,  2, 1, 0};
        vecs[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1, 1, 1, 6,  1, 1, 0};
        vecs[8]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1, 1, 1, 6,  1, 1, 0};
        vecs[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 0, 0, 0, 0,  0, 1, 0};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[11] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1, 0, 2, 11, 1, 0, 0};
        vecs[12] = '{1'b0, 4'b0001, 1'b1, 1'b0, 0, 0, 0, 0,  0, 0, 0};
        vecs[13] = '{1'b0, 4'b1000, 1'b0, 1'b1, 1, 3, 3, 13, 1, 0, 0};
        vecs[14] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1, 1, 4, 14, 1, 0, 0};
        vecs[15] = '{1'b0, 4'b0000, 1'b0, 1'b1, 0, 0, 0, 0,  0, 0, 0};

        reset = 1'b1;
        step(0, 4'b0, 0, 0);
        step(0, 4'b0, 0, 0);
        reset = 1'b0;

        check("reset.out_valid", out_valid, 0);
        check("reset.out_cand", out_cand, 0);
        check("reset.out_seq", out_seq, 0);
        check("reset.out_ts", out_ts, 0);
        check("reset.level", level, 0);
        check("reset.full", full, 0);
        check("reset.dropped", dropped, 0);
        check("reset.collisions", collisions, 0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].m, vecs[i].vv, vecs[i].clr, vecs[i].rdy);
            check($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].ev);
            check($sformatf("vec%0d.level", i), level, vecs[i].elev);
            check($sformatf("vec%0d.full", i), full, 0);
            check($sformatf("vec%0d.collisions", i), collisions, vecs[i].ecoll);
            check($sformatf("vec%0d.dropped", i), dropped, vecs[i].edrop);
            if (vecs[i].ev != 0) begin
                check($sformatf("vec%0d.out_cand", i), out_cand, vecs[i].ec);
                check($sformatf("vec%0d.out_seq", i), out_seq, vecs[i].es);
                check($sformatf("vec%0d.out_ts", i), out_ts, vecs[i].ets);
            end
            $display("vec %0d: valid=%0d cand=%0d seq=%0d ts=%0d level=%0d coll=%0d",
                     i, out_valid, out_cand, out_seq, out_ts, level, collisions);
        end

        // Fill past capacity, then push+pop while full, then drain in order.
        step(0, 4'b0, 1, 0);
        s0 = m_seq;
        for (int i = 0; i < 18; i++) step(0, 4'b0001 << $urandom_range(0, 3), 0, 0);
        check("fill.level", level, 16);
        check("fill.full", full, 1);
        check("fill.dropped", dropped, 2);
        check("fill.head_seq", out_seq, s0);
        $display("fill: level=%0d full=%0d dropped=%0d", level, full, dropped);
        step(0, 4'b0100, 0, 1);
        check("fullpp.level", level, 16);
        check("fullpp.full", full, 1);
        check("fullpp.dropped", dropped, 2);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("drain%0d.out_valid", k), out_valid, 1);
            check($sformatf("drain%0d.out_seq", k), out_seq, (s0 + k) % 256);
            $display("drain %0d: seq=%0d level=%0d", k, out_seq, level);
            step(0, 4'b0, 0, 1);
        end
        check("drain.out_valid", out_valid, 0);
        check("drain.level", level, 0);

        // Sustained streaming through a seq wrap, with a clear mid-stream.
        last_seq = -1;
        saw_wrap = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                step(0, 4'b0010, 1, 1);
                check("midclear.out_valid", out_valid, 0);
                check("midclear.level", level, 0);
                check("midclear.dropped", dropped, 0);
                check("midclear.collisions", collisions, 0);
                $display("stream clear: valid=%0d level=%0d", out_valid, level);
            end else begin
                step(0, 4'b0001 << $urandom_range(0, 3), 0, 1);
                check_model($sformatf("stream%0d", i));
                if (out_valid) begin
                    if (last_seq == 255 && out_seq == 0) saw_wrap = 1;
                    last_seq = out_seq;
                end
                $display("stream %0d: valid=%0d seq=%0d ts=%0d", i, out_valid, out_seq, out_ts);
            end
        end
        check("stream.seq_wrap_seen", saw_wrap, 1);

        // Randomized traffic against the queue model, with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                reset = 1'b1;
                step(0, rand_vote(), 0, 1);
                reset = 1'b0;
                check_model("rand.reset");
                check("rand.reset.out_ts_zero_cycle", m_ts, 0);
            end
            vv = rand_vote();
            step(($urandom_range(0, 7) == 0), vv, ($urandom_range(0, 63) == 0),
                 ((i / 200) % 2 == 1) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0));
            check_model($sformatf("rand%0d", i));
            $display("rand %0d: vv=%b valid=%0d seq=%0d level=%0d drop=%0d coll=%0d",
                     i, vv, out_valid, out_seq, level, dropped, collisions);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
